// File: rtl/lc3b_types_pkg.sv
// Shared LC-3b cache datapath types: default line/offset types and the
// line_word_stream state encoding.
package lc3b_types;

    typedef logic [127:0] lc3b_memband;
    typedef logic [2:0]   lc3b_c_offset;

    localparam int LC3B_LINE_W = $bits(lc3b_memband);
    localparam int LC3B_WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        WRITE
    } lc3b_lws_state_t;

endpackage

// File: rtl/line_word_merge.sv
// Combinational byte-masked merge of one word into a cache line.
// Shared with the cache write path.
module line_word_merge
    import lc3b_types::*;
#(
    parameter  int LINE_W = LC3B_LINE_W,
    parameter  int WORD_W = LC3B_WORD_W,
    localparam int WORDS  = LINE_W / WORD_W,
    localparam int OFF_W  = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic [LINE_W-1:0]   line,
    input  logic [OFF_W-1:0]    offset,
    input  logic [WORD_W-1:0]   wdata,
    input  logic [WORD_W/8-1:0] wmask,
    output logic [LINE_W-1:0]   merged
);

    always_comb begin
        merged = line;
        for (int i = 0; i < WORD_W / 8; i++) begin
            if (wmask[i]) begin
                merged[int'(offset) * WORD_W + 8 * i +: 8] = wdata[8 * i +: 8];
            end
        end
    end

endmodule

// File: rtl/line_word_stream.sv
// Cache-line word engine: critical-word-first read bursts over rd_*,
// byte-masked word merge presented as a full line over wr_*.
module line_word_stream
    import lc3b_types::*;
#(
    parameter  int LINE_W = LC3B_LINE_W,
    parameter  int WORD_W = LC3B_WORD_W,
    localparam int WORDS  = LINE_W / WORD_W,
    localparam int OFF_W  = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [OFF_W-1:0]    req_offset,
    input  logic [OFF_W-1:0]    req_len,
    input  logic [LINE_W-1:0]   req_line,
    input  logic [WORD_W-1:0]   req_wdata,
    input  logic [WORD_W/8-1:0] req_wmask,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic [WORD_W-1:0]   rd_data,
    output logic [OFF_W-1:0]    rd_offset,
    output logic                rd_last,
    output logic                wr_valid,
    input  logic                wr_ready,
    output logic [LINE_W-1:0]   wr_line
);

    lc3b_lws_state_t state_q, state_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [OFF_W-1:0]  cur_q, cur_d;
    logic [OFF_W-1:0]  rem_q, rem_d;
    logic [WORD_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_last_q, rd_last_d;
    logic              wr_valid_q, wr_valid_d;
    logic [LINE_W-1:0] wr_line_q, wr_line_d;
    logic [LINE_W-1:0] merged_line;
    logic [OFF_W-1:0]  nxt_off;

    line_word_merge #(
        .LINE_W(LINE_W),
        .WORD_W(WORD_W)
    ) u_merge (
        .line  (req_line),
        .offset(req_offset),
        .wdata (req_wdata),
        .wmask (req_wmask),
        .merged(merged_line)
    );

    // WORDS need not be a power of two, so wrap explicitly.
    assign nxt_off = (cur_q == OFF_W'(WORDS - 1)) ? '0 : cur_q + OFF_W'(1);

    always_comb begin
        state_d    = state_q;
        line_d     = line_q;
        cur_d      = cur_q;
        rem_d      = rem_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
        rd_last_d  = rd_last_q;
        wr_valid_d = wr_valid_q;
        wr_line_d  = wr_line_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    line_d = req_line;
                    if (req_write) begin
                        wr_line_d  = merged_line;
                        wr_valid_d = 1'b1;
                        state_d    = WRITE;
                    end else begin
                        cur_d      = req_offset;
                        rem_d      = req_len;
                        rd_data_d  = req_line[int'(req_offset) * WORD_W +: WORD_W];
                        rd_last_d  = (req_len == '0);
                        rd_valid_d = 1'b1;
                        state_d    = STREAM;
                    end
                end
            end
            STREAM: begin
                if (rd_ready) begin
                    if (rem_q == '0) begin
                        rd_valid_d = 1'b0;
                        rd_last_d  = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        cur_d     = nxt_off;
                        rem_d     = rem_q - OFF_W'(1);
                        rd_data_d = line_q[int'(nxt_off) * WORD_W +: WORD_W];
                        rd_last_d = (rem_q == OFF_W'(1));
                    end
                end
            end
            WRITE: begin
                if (wr_ready) begin
                    wr_valid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            line_q     <= '0;
            cur_q      <= '0;
            rem_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_line_q  <= '0;
        end else begin
            state_q    <= state_d;
            line_q     <= line_d;
            cur_q      <= cur_d;
            rem_q      <= rem_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
            wr_valid_q <= wr_valid_d;
            wr_line_q  <= wr_line_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign rd_offset = cur_q;
    assign rd_last   = rd_last_q;
    assign wr_valid  = wr_valid_q;
    assign wr_line   = wr_line_q;

endmodule

// File: tb/tb_line_word_stream.sv
// Randomized bench for line_word_stream against a word-array reference model,
// plus a second instance at LINE_W=256 / WORD_W=32.
module tb_line_word_stream;

    localparam int LW = 128;
    localparam int WW = 16;
    localparam int NW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic          req_valid, req_ready, req_write;
    logic [2:0]    req_offset, req_len;
    logic [LW-1:0] req_line;
    logic [WW-1:0] req_wdata;
    logic [1:0]    req_wmask;
    logic          rd_valid, rd_ready, rd_last;
    logic [WW-1:0] rd_data;
    logic [2:0]    rd_offset;
    logic          wr_valid, wr_ready;
    logic [LW-1:0] wr_line;

    logic         w_req_valid, w_req_ready, w_req_write;
    logic [2:0]   w_req_offset, w_req_len;
    logic [255:0] w_req_line;
    logic [31:0]  w_req_wdata;
    logic [3:0]   w_req_wmask;
    logic         w_rd_valid, w_rd_ready, w_rd_last;
    logic [31:0]  w_rd_data;
    logic [2:0]   w_rd_offset;
    logic         w_wr_valid, w_wr_ready;
    logic [255:0] w_wr_line;

    int total = 0;
    int bad   = 0;

    logic [WW-1:0] words[NW];

    line_word_stream dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_offset(req_offset),
        .req_len   (req_len),
        .req_line  (req_line),
        .req_wdata (req_wdata),
        .req_wmask (req_wmask),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_offset (rd_offset),
        .rd_last   (rd_last),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_line   (wr_line)
    );

    line_word_stream #(
        .LINE_W(256),
        .WORD_W(32)
    ) dut_wide (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (w_req_valid),
        .req_ready (w_req_ready),
        .req_write (w_req_write),
        .req_offset(w_req_offset),
        .req_len   (w_req_len),
        .req_line  (w_req_line),
        .req_wdata (w_req_wdata),
        .req_wmask (w_req_wmask),
        .rd_valid  (w_rd_valid),
        .rd_ready  (w_rd_ready),
        .rd_data   (w_rd_data),
        .rd_offset (w_rd_offset),
        .rd_last   (w_rd_last),
        .wr_valid  (w_wr_valid),
        .wr_ready  (w_wr_ready),
        .wr_line   (w_wr_line)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] pack_words();
        logic [LW-1:0] l;
        for (int k = 0; k < NW; k++) l[k*WW +: WW] = words[k];
        return l;
    endfunction

    task automatic junk_request();
        req_valid  = 1'($urandom);
        req_write  = 1'($urandom);
        req_offset = 3'($urandom);
        req_len    = 3'($urandom);
        req_line   = {4{$urandom}};
        req_wdata  = 16'($urandom);
        req_wmask  = 2'($urandom);
    endtask

    // mode 0: rd_ready always 1; 1: pattern 1,0,0 repeating; 2: random
    task automatic run_read(input int off, input int len, input int mode);
        int k;
        int c;
        int o;
        check("rd_idle_before", 256'(req_ready), 256'(1));
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_offset = 3'(off);
        req_len    = 3'(len);
        req_line   = pack_words();
        req_wdata  = 16'($urandom);
        req_wmask  = 2'($urandom);
        @(negedge clk);
        k = 0;
        c = 0;
        while (k <= len && c < 200) begin
            o = (off + k) % NW;
            check("rd_valid", 256'(rd_valid), 256'(1));
            check("rd_data", 256'(rd_data), 256'(words[o]));
            check("rd_offset", 256'(rd_offset), 256'(o));
            check("rd_last", 256'(rd_last), 256'(k == len));
            check("rd_busy", 256'(req_ready), 256'(0));
            check("rd_no_wr", 256'(wr_valid), 256'(0));
            junk_request();
            case (mode)
                0:       rd_ready = 1'b1;
                1:       rd_ready = (c % 3 == 0);
                default: rd_ready = 1'($urandom);
            endcase
            @(negedge clk);
            if (rd_ready) k++;
            c++;
        end
        check("rd_timeout", 256'(c < 200), 256'(1));
        check("rd_done_valid", 256'(rd_valid), 256'(0));
        check("rd_done_idle", 256'(req_ready), 256'(1));
        req_valid = 1'b0;
        rd_ready  = 1'b0;
    endtask

    task automatic run_write(input int off, input logic [15:0] wd, input logic [1:0] wm,
                             input int hold);
        logic [WW-1:0] bm;
        logic [LW-1:0] exp_line;
        int c;
        bm = {{8{wm[1]}}, {8{wm[0]}}};
        exp_line = pack_words();
        exp_line[off*WW +: WW] = (words[off] & ~bm) | (wd & bm);
        check("wr_idle_before", 256'(req_ready), 256'(1));
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_offset = 3'(off);
        req_len    = 3'($urandom);
        req_line   = pack_words();
        req_wdata  = wd;
        req_wmask  = wm;
        @(negedge clk);
        c = 0;
        while (c <= hold) begin
            check("wr_valid", 256'(wr_valid), 256'(1));
            check("wr_line", 256'(wr_line), 256'(exp_line));
            check("wr_busy", 256'(req_ready), 256'(0));
            check("wr_no_rd", 256'(rd_valid), 256'(0));
            junk_request();
            wr_ready = (c == hold);
            @(negedge clk);
            c++;
        end
        check("wr_done_valid", 256'(wr_valid), 256'(0));
        check("wr_done_idle", 256'(req_ready), 256'(1));
        req_valid = 1'b0;
        wr_ready  = 1'b0;
    endtask

    task automatic set_ramp();
        for (int k = 0; k < NW; k++) words[k] = 16'h1000 + 16'(k);
    endtask

    initial begin
        reset_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_offset = '0; req_len = '0;
        req_line = '0; req_wdata = '0; req_wmask = '0; rd_ready = 1'b0; wr_ready = 1'b0;
        w_req_valid = 1'b0; w_req_write = 1'b0; w_req_offset = '0; w_req_len = '0;
        w_req_line = '0; w_req_wdata = '0; w_req_wmask = '0; w_rd_ready = 1'b0;
        w_wr_ready = 1'b0;
        @(negedge clk);
        check("rst_req_ready", 256'(req_ready), 256'(1));
        check("rst_rd_valid", 256'(rd_valid), 256'(0));
        check("rst_rd_last", 256'(rd_last), 256'(0));
        check("rst_wr_valid", 256'(wr_valid), 256'(0));
        check("rst_rd_data", 256'(rd_data), 256'(0));
        check("rst_rd_offset", 256'(rd_offset), 256'(0));
        check("rst_wr_line", 256'(wr_line), 256'(0));
        reset_n = 1'b1;
        @(negedge clk);

        set_ramp();
        run_read(3, 0, 0);
        run_read(6, 7, 0);
        run_read(0, 3, 1);
        run_write(2, 16'hBEEF, 2'b10, 3);
        run_write(5, 16'h1234, 2'b00, 0);
        run_write(7, 16'hCAFE, 2'b11, 0);

        // reset during beat 2 of an 8-beat burst
        set_ramp();
        req_valid = 1'b1; req_write = 1'b0; req_offset = 3'd0; req_len = 3'd7;
        req_line = pack_words();
        @(negedge clk);
        req_valid = 1'b0;
        rd_ready  = 1'b1;
        @(negedge clk);
        check("mid_beat2_off", 256'(rd_offset), 256'(1));
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_rd_valid", 256'(rd_valid), 256'(0));
        check("mid_rst_req_ready", 256'(req_ready), 256'(1));
        check("mid_rst_rd_last", 256'(rd_last), 256'(0));
        rd_ready = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_no_beat", 256'(rd_valid), 256'(0));
        run_read(5, 2, 0);

        // wide instance: 4-beat read from offset 7 wraps 7,0,1,2
        for (int k = 0; k < 8; k++) w_req_line[k*32 +: 32] = 32'hA000_0000 + 32'(k);
        w_req_valid = 1'b1; w_req_offset = 3'd7; w_req_len = 3'd3; w_rd_ready = 1'b1;
        @(negedge clk);
        w_req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("wide_valid", 256'(w_rd_valid), 256'(1));
            check("wide_offset", 256'(w_rd_offset), 256'((7 + k) % 8));
            check("wide_data", 256'(w_rd_data), 256'(32'hA000_0000 + 32'((7 + k) % 8)));
            check("wide_last", 256'(w_rd_last), 256'(k == 3));
            @(negedge clk);
        end
        check("wide_done_valid", 256'(w_rd_valid), 256'(0));
        check("wide_done_idle", 256'(w_req_ready), 256'(1));
        w_rd_ready = 1'b0;

        for (int t = 0; t < 40; t++) begin
            for (int k = 0; k < NW; k++) words[k] = 16'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                run_write(int'($urandom_range(0, 7)), 16'($urandom), 2'($urandom),
                          int'($urandom_range(0, 3)));
            end else begin
                run_read(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                         int'($urandom_range(0, 2)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/line_word_stream.md
# line_word_stream

Parametrised cache-line word access engine that sits between the cache datapath and its consumers. It is the sequential successor to the fixed 8:1 line-word selector.
- Read mode: accepts a full line plus a starting word offset and streams 1..WORDS words critical-word-first, wrapping modulo the line, over a valid/ready port.
- Write mode: merges one byte-masked word into the line and presents the updated line over a second valid/ready port.

## Interface
Parameters:
- LINE_W, 128, line width in bits; must be a multiple of WORD_W.
- WORD_W, 16, word width in bits; must be a multiple of 8.
- WORDS, LINE_W/WORD_W (derived, not overridable), words per line.
- OFF_W, $clog2(WORDS) (derived), offset width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when high together with req_valid.
- req_write  in  1  1 = write-merge, 0 = read stream.
- req_offset  in  OFF_W  starting word (read) or target word (write).
- req_len  in  OFF_W  read beat count minus 1 (0 = 1 word, WORDS-1 = whole line); ignored for writes.
- req_line  in  LINE_W  source line; word k occupies bits [k*WORD_W +: WORD_W].
- req_wdata  in  WORD_W  write data.
- req_wmask  in  WORD_W/8  byte enables; bit i covers bits [8i +: 8] of the word.
- rd_valid  out  1  read beat valid.
- rd_ready  in  1  consumer accepts the beat.
- rd_data  out  WORD_W  beat data.
- rd_offset  out  OFF_W  word index of the current beat.
- rd_last  out  1  final beat of the burst.
- wr_valid  out  1  merged line valid.
- wr_ready  in  1  consumer accepts the line.
- wr_line  out  LINE_W  merged line.

## Operation
- FSM states: IDLE, STREAM, WRITE. Reset enters IDLE.
- req_ready is 1 only in IDLE.
- On acceptance (req_valid & req_ready):
  - Register line, offset and length.
  - Read requests: cur_off = req_offset, remaining = req_len; go to STREAM.
  - Write requests: compute the merge, register it; go to WRITE.
- STREAM:
  - rd_valid = 1.
  - rd_data = registered line word at cur_off; rd_offset = cur_off.
  - rd_last = (remaining == 0).
  - On rd_valid & rd_ready: cur_off increments modulo WORDS (wraps from WORDS-1 to 0) and remaining decrements. On the last beat, go to IDLE.
  - rd_ready low: all outputs hold stable.
- WRITE:
  - wr_valid = 1; wr_line = registered merged line.
  - On wr_ready, go to IDLE.
  - Merge rule: word req_offset, byte i = wdata byte i if wmask[i], otherwise the original byte. All other words are unchanged.
  - wmask = 0 still completes the handshake, with wr_line equal to req_line.
- Only one transaction is in flight at a time. Request inputs are ignored outside IDLE.
- Reset asserted mid-burst or mid-write aborts the transaction immediately. No partial beat is presented after reset.

## Timing
- Reset values: req_ready = 1 (IDLE); rd_valid, rd_last, wr_valid = 0; rd_data, rd_offset, wr_line = 0.
- Request accepted at edge N → first rd_valid or wr_valid high in cycle N+1. All outputs come from registers.
- Burst of L = req_len+1 beats with rd_ready held high: beats in cycles N+1..N+L; IDLE (req_ready = 1) in cycle N+L+1.
- Back-to-back requests: at least one idle cycle between transactions.
- Write with wr_ready high: wr_valid for exactly one cycle (N+1); IDLE in N+2.

## Structure
- Shared package lc3b_types:
  - lc3b_memband and lc3b_c_offset stay as the default-parameter types.
  - Add a state enum lc3b_lws_state_t {IDLE, STREAM, WRITE}.
- Sub-module line_word_merge (combinational): line, offset, wdata, wmask → merged line. It is reusable by the cache write path.
- Word extraction uses an indexed part-select on the parameters, not a hand-enumerated case.

## Test plan
- Read, offset 3, len 0, line words k = 16'h1000+k, rd_ready = 1 → one beat: rd_data = 16'h1003, rd_offset = 3, rd_last = 1; req_ready back at cycle N+2.
- Read, offset 6, len 7 (full line, wrap) → offsets 6,7,0,1,2,3,4,5, data 16'h1006…16'h1005; rd_last only on offset 5.
- Read, offset 0, len 3, rd_ready toggling 1,0,0,1,… → each beat held stable while rd_ready = 0; exactly 4 beats, none duplicated or skipped.
- Write, offset 2, wdata 16'hBEEF, wmask 2'b10, word 2 = 16'h1002 → wr_line word 2 = 16'hBE02, all other words unchanged; wr_valid held until wr_ready.
- Write with wmask 2'b00 → wr_line == req_line; the handshake completes.
- reset_n pulsed low during beat 2 of an 8-beat burst → rd_valid = 0 and req_ready = 1 asynchronously; the next request streams from its own offset.
- Parameter run LINE_W = 256, WORD_W = 32 (WORDS = 8): 4-beat read from offset 7 wraps 7,0,1,2.
